mrly240314_v02: RTL and testbench
=================================

MRLY240314_V02 -- requirements
Module: mrly240314_v02

Interface
REQ-001 SHALL have parameter WIDTH, default 472: bit width of the flat `memory` input; WIDTH/8 readable bytes.
REQ-002 SHALL have parameter DIVISOR, default 4: `clk_div` divide ratio; even, >=2.
REQ-003 SHALL have parameter LED_HALF, default 25_000_000: `clk` cycles per `live_led` half-period (0.5 s at 50 MHz).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  50 MHz system clock, sole clock of the block.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port live_led  out  1  heartbeat LED.
REQ-007 SHALL have port clk_div  out  1  clk/DIVISOR, 50% duty (12.5 MHz default).
REQ-008 SHALL have port diag_clk  in  1  SPI master clock, asynchronous to clk, mode 0.
REQ-009 SHALL have port diag_cs_n  in  1  SPI chip select, active low, asynchronous.
REQ-010 SHALL have port diag_mosi  in  1  SPI data from master, asynchronous.
REQ-011 SHALL have port diag_miso  out  1  SPI data to master.
REQ-012 SHALL have port memory  in  WIDTH  flat memory image; byte n = memory[8n+7:8n].

Function
REQ-013 `clk_div` SHALL toggle every DIVISOR/2 clk cycles.
- DIVISOR=4: high 2 cycles, low 2 cycles.
- Counter restarts on reset.
REQ-014 `live_led` SHALL toggle every LED_HALF clk cycles.
REQ-015 diag_clk, diag_cs_n and diag_mosi SHALL each pass through a 2-flop synchronizer in the clk domain.
- SPI edges are detected from the synchronized diag_clk.
- Supported SCK: <= clk/8; each high and low phase >= 4 clk cycles.
REQ-016 Transaction framing:
- A transaction starts on the synchronized diag_cs_n falling edge.
- The start clears the bit counter and the shift register.
- A transaction ends when synchronized diag_cs_n is high; all transaction state then returns to idle.
REQ-017 On each synchronized diag_clk rising edge with cs low, the slave SHALL shift in diag_mosi, MSB first.
REQ-018 Header: bits 1-8 are the instruction, bits 9-24 the 16-bit byte address, MSB first.
REQ-019 Read instruction: 0x03 = READ; any other instruction SHALL yield miso=0 for the whole transaction.
REQ-020 On the 24th falling edge of a READ, the slave SHALL load the addressed byte and drive its bit7 on diag_miso.
REQ-021 On falling edges 25-31, the slave SHALL present bit6..bit0 in order.
- diag_miso changes within 4 clk cycles of the raw diag_clk falling edge.
- The master samples after the falling edge, before the next rising edge.
REQ-022 Burst read: after each 8 data bits the address SHALL increment and the next byte SHALL be loaded on the following falling edge.
REQ-023 An address >= WIDTH/8 SHALL read as 0x00, including addresses reached by burst increment; the address does not wrap.
REQ-024 diag_miso SHALL be 0 in all of these cases:
- during the header;
- while cs is high;
- outside a READ.
REQ-025 The memory byte SHALL be captured at load time; later changes to `memory` affect only the next byte.
REQ-026 The slave SHALL ignore diag_clk edges while cs is high.
REQ-027 cs deasserting mid-header or mid-byte SHALL abort the transaction with no side effects; the next cs fall starts fresh.

Reset
REQ-028 While reset is high at a clk edge, the block SHALL drive live_led=0, clk_div=0 and diag_miso=0.
REQ-029 Reset SHALL clear all counters, the synchronizers, the header register and the SPI state to idle.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction; after release, the slave waits for a new cs falling edge.

Verification
REQ-031 Divider: release reset, run 16 clk -> clk_div pattern 0,0,1,1 repeating; first high on cycles 3-4 after release.
REQ-032 SPI read: memory byte 7 = 0x55; cs low; send header 0x030007 plus 8 dummy bits, SCK = clk/8 -> last 8 miso bits = 0x55, first 24 bits = 0.
REQ-033 Burst read: bytes 2,3 = 0xA5,0x3C; header 0x030002 plus 16 bits -> 0xA5 then 0x3C.
REQ-034 Out-of-range and bad instruction:
- header 0x0300FF (WIDTH=472) -> data 0x00;
- header 0x020007 -> all-zero miso.
REQ-035 Abort: cs high after 10 header bits, then full READ of address 0 with byte 0 = 0x43 -> 0x43.
REQ-036 LED: LED_HALF=5, run 20 clk after reset -> live_led toggles at cycles 5, 10, 15, 20.

Source files
------------

// File: rtl/mrly240314_v02_if.sv
// Diagnostic SPI port (mode 0): the master owns clock, select and data-out; the slave returns miso.
interface mrly240314_v02_if;
    // No valid/ready pair: a bit transfers on each diag_clk rising edge while diag_cs_n is low,
    // and the slave updates diag_miso only after diag_clk falling edges.
    logic diag_clk;
    logic diag_cs_n;
    logic diag_mosi;
    logic diag_miso;

    modport master (output diag_clk, output diag_cs_n, output diag_mosi, input diag_miso);
    modport slave  (input diag_clk, input diag_cs_n, input diag_mosi, output diag_miso);
endinterface

// File: rtl/mrly240314_v02.sv
// Heartbeat LED, clock divider and an SPI-mode-0 read-only slave serving bytes of a flat memory image.
// All SPI inputs are oversampled in the clk domain; SCK must be clk/8 or slower.
module mrly240314_v02 #(
    parameter int WIDTH    = 472,
    parameter int DIVISOR  = 4,
    parameter int LED_HALF = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    output logic             live_led,
    output logic             clk_div,
    mrly240314_v02_if.slave  diag,
    input  logic [WIDTH-1:0] memory,
    output logic [1:0]       dbg_state
);
    localparam int NBYTES = WIDTH / 8;
    localparam int AW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int DW     = (DIVISOR / 2 > 1) ? $clog2(DIVISOR / 2) : 1;
    localparam int LW     = (LED_HALF > 1) ? $clog2(LED_HALF) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIVISOR / 2 - 1);
    localparam logic [LW-1:0] LED_LAST = LW'(LED_HALF - 1);
    localparam logic [16:0]   ADDR_END = 17'(NBYTES);
    localparam logic [7:0]    READ_CMD = 8'h03;

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_READ, S_IGNORE} spi_state_t;

    logic [DW-1:0] div_cnt;
    logic [LW-1:0] led_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            clk_div <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            clk_div <= ~clk_div;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_cnt  <= '0;
            live_led <= 1'b0;
        end else if (led_cnt == LED_LAST) begin
            led_cnt  <= '0;
            live_led <= ~live_led;
        end else begin
            led_cnt <= led_cnt + LW'(1);
        end
    end

    // Two-flop synchronizers plus one history flop each for edge detection.
    logic [1:0] sck_sync, cs_sync, mosi_sync;
    logic       sck_prev, cs_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], diag.diag_clk};
            cs_sync   <= {cs_sync[0], diag.diag_cs_n};
            mosi_sync <= {mosi_sync[0], diag.diag_mosi};
            sck_prev  <= sck_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_fall;
    assign sck_s    = sck_sync[1];
    assign cs_s     = cs_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_fall  = ~cs_s & cs_prev;

    // Bytes beyond the image are padded with zero so the lookup needs no out-of-range index.
    logic [7:0] mem_bytes [2**AW];
    for (genvar i = 0; i < 2**AW; i++) begin : g_bytes
        if (i < NBYTES) begin : g_img
            assign mem_bytes[i] = memory[8*i +: 8];
        end else begin : g_pad
            assign mem_bytes[i] = 8'h00;
        end
    end

    spi_state_t  state, state_next;
    logic [4:0]  hdr_cnt;
    logic [22:0] shift;
    logic [23:0] shift_next;
    logic [16:0] addr;
    logic [7:0]  data_reg;
    logic [2:0]  bit_idx;
    logic        miso_q;
    logic [7:0]  cur_byte;
    logic        start, hdr_shift, hdr_done, data_edge;

    assign shift_next = {shift, mosi_s};
    assign cur_byte   = (addr < ADDR_END) ? mem_bytes[addr[AW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        hdr_shift  = 1'b0;
        hdr_done   = 1'b0;
        data_edge  = 1'b0;
        if (cs_s) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cs_fall) begin
                        start      = 1'b1;
                        state_next = S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (sck_rise) begin
                        hdr_shift = 1'b1;
                        if (hdr_cnt == 5'd23) begin
                            hdr_done   = 1'b1;
                            state_next = (shift_next[23:16] == READ_CMD) ? S_READ : S_IGNORE;
                        end
                    end
                end
                S_READ:   data_edge = sck_fall;
                default:  ;
            endcase
        end
    end

    // bit_idx==0 marks a byte boundary: the next falling edge fetches a fresh byte.
    always_ff @(posedge clk) begin
        if (reset || cs_s) begin
            hdr_cnt  <= '0;
            shift    <= '0;
            addr     <= '0;
            data_reg <= '0;
            bit_idx  <= '0;
            miso_q   <= 1'b0;
        end else begin
            if (start) begin
                hdr_cnt <= '0;
                shift   <= '0;
            end
            if (hdr_shift) begin
                shift   <= shift_next[22:0];
                hdr_cnt <= hdr_cnt + 5'd1;
            end
            if (hdr_done) begin
                addr    <= {1'b0, shift_next[15:0]};
                bit_idx <= '0;
            end
            if (data_edge) begin
                if (bit_idx == 3'd0) begin
                    miso_q   <= cur_byte[7];
                    data_reg <= {cur_byte[6:0], 1'b0};
                    bit_idx  <= 3'd7;
                    if (!addr[16]) begin
                        addr <= addr + 17'd1;
                    end
                end else begin
                    miso_q   <= data_reg[7];
                    data_reg <= {data_reg[6:0], 1'b0};
                    bit_idx  <= bit_idx - 3'd1;
                end
            end
        end
    end

    assign diag.diag_miso = miso_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_mrly240314_v02.sv
// Directed bench for mrly240314_v02: divider/LED timing every cycle, SPI reads bit by bit against a byte-level model.
module tb_mrly240314_v02;
  localparam int W   = 472;
  localparam int NB  = W / 8;
  localparam int DIV = 4;
  localparam int LH  = 5;

  logic         clk;
  logic         reset;
  logic         live_led;
  logic         clk_div;
  logic [W-1:0] mem;
  logic [1:0]   dbg_state;

  mrly240314_v02_if diag();

  mrly240314_v02 #(.WIDTH(W), .DIVISOR(DIV), .LED_HALF(LH)) dut (
    .clk       (clk),
    .reset     (reset),
    .live_led  (live_led),
    .clk_div   (clk_div),
    .diag      (diag),
    .memory    (mem),
    .dbg_state (dbg_state)
  );

  // clock / reset bookkeeping
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   k = 0;
  logic rst_q = 1'b0;
  logic started = 1'b0;
  always @(posedge clk) begin
    started <= 1'b1;
    rst_q   <= reset;
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: value the master must see when sampling before rising edge p
  logic [7:0]  cur_instr;
  logic [15:0] cur_addr;
  int          cur_p;
  int          cur_cut;
  logic        sample_req = 1'b0;

  function automatic logic exp_bit(input logic [7:0] instr, input logic [15:0] addr, input int p, input int cut);
    int idx;
    int b;
    if (p <= 24 || p > cut || instr != 8'h03) return 1'b0;
    idx = int'(addr) + (p - 25) / 8;
    b   = 7 - (p - 25) % 8;
    if (idx >= NB) return 1'b0;
    return mem[idx*8 + b];
  endfunction

  // compare process
  int cs_hi = 0;
  always @(negedge clk) begin
    if (started) begin
      check("clk_div", {31'd0, clk_div}, {31'd0, 1'((k / (DIV / 2)) % 2)});
      check("live_led", {31'd0, live_led}, {31'd0, 1'((k / LH) % 2)});
      if (diag.diag_cs_n) cs_hi++;
      else                cs_hi = 0;
      if (rst_q || cs_hi >= 4)
        check("miso_idle", {31'd0, diag.diag_miso}, 32'd0);
      if (sample_req) begin
        exp_q.push_back(exp_bit(cur_instr, cur_addr, cur_p, cur_cut));
        check("miso_bit", {31'd0, diag.diag_miso}, {31'd0, exp_q.pop_front()});
        sample_req = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_txn(input logic [7:0] instr, input logic [15:0] addr, input int ndata,
                         input int stop_after, input int reset_after, output logic [15:0] rx);
    logic [23:0] hdr;
    int nbits;
    hdr   = {instr, addr};
    nbits = 24 + ndata;
    if (stop_after > 0 && stop_after < nbits) nbits = stop_after;
    rx        = '0;
    cur_instr = instr;
    cur_addr  = addr;
    cur_cut   = (reset_after > 0) ? reset_after : 1000;
    diag.diag_cs_n = 1'b0;
    wait_clk(6);
    for (int p = 1; p <= nbits; p++) begin
      diag.diag_mosi = (p <= 24) ? hdr[24-p] : 1'b0;
      wait_clk(3);
      @(posedge clk);
      cur_p      = p;
      sample_req = 1'b1;
      @(negedge clk);
      if (p > 24) rx = {rx[14:0], diag.diag_miso};
      diag.diag_clk = 1'b1;
      wait_clk(4);
      diag.diag_clk = 1'b0;
      if (reset_after == p) begin
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
      end
    end
    wait_clk(4);
    diag.diag_cs_n = 1'b1;
    diag.diag_mosi = 1'b0;
    wait_clk(8);
  endtask

  logic [20:0] led_vec;
  logic [7:0]  div_vec;
  logic [15:0] rx;

  initial begin
    reset          = 1'b1;
    diag.diag_clk  = 1'b0;
    diag.diag_cs_n = 1'b1;
    diag.diag_mosi = 1'b0;
    for (int i = 0; i < W / 32 + 1; i++) begin
      if (i * 32 + 32 <= W) mem[i*32 +: 32] = $urandom;
      else                  mem[W-1 -: 24] = 24'($urandom_range(0, 24'hFFFFFF));
    end
    mem[0*8 +: 8]  = 8'h43;
    mem[2*8 +: 8]  = 8'hA5;
    mem[3*8 +: 8]  = 8'h3C;
    mem[7*8 +: 8]  = 8'h55;
    mem[58*8 +: 8] = 8'h9E;

    wait_clk(5);
    check("reset_led", {31'd0, live_led}, 32'd0);
    check("reset_div", {31'd0, clk_div}, 32'd0);
    check("reset_miso", {31'd0, diag.diag_miso}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      led_vec[i] = live_led;
      if (i < 8) div_vec[i] = clk_div;
      @(negedge clk);
    end
    check("div_pattern", {24'd0, div_vec}, {24'd0, 8'b1100_1100});
    check("led_pattern", {11'd0, led_vec}, {11'd0, 21'b0_11111_00000_11111_00000});

    spi_txn(8'h03, 16'h0007, 8, 0, 0, rx);
    check("read_byte7", {24'd0, rx[7:0]}, 32'h55);

    spi_txn(8'h03, 16'h0002, 16, 0, 0, rx);
    check("burst_2_3", {16'd0, rx}, 32'hA53C);

    spi_txn(8'h03, 16'h00FF, 8, 0, 0, rx);
    check("out_of_range", {24'd0, rx[7:0]}, 32'h00);

    spi_txn(8'h02, 16'h0007, 8, 0, 0, rx);
    check("bad_instr", {24'd0, rx[7:0]}, 32'h00);

    spi_txn(8'h03, 16'h0000, 8, 10, 0, rx);
    spi_txn(8'h03, 16'h0000, 8, 0, 0, rx);
    check("after_abort", {24'd0, rx[7:0]}, 32'h43);

    spi_txn(8'h03, 16'd58, 16, 0, 0, rx);
    check("burst_past_end", {16'd0, rx}, 32'h9E00);

    spi_txn(8'h03, 16'h0007, 8, 0, 28, rx);
    check("reset_mid_txn", {24'd0, rx[7:0]}, 32'h50);

    spi_txn(8'h03, 16'h0003, 8, 0, 0, rx);
    check("read_after_reset", {24'd0, rx[7:0]}, 32'h3C);

    wait_clk(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
